// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers: state encoding and
// the default payload/control widths used by every stage instance.
package pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CTRL_W = 12;

   // Encoding doubles as the held-entry count driven on the count port.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages; the stage register uses the
// slave view, the surrounding pipeline (or bench) drives the master view.
interface pipe_stage_reg_if #(
   parameter int DATA_W = pipe_pkg::DEF_DATA_W,
   parameter int CTRL_W = pipe_pkg::DEF_CTRL_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        count;

   modport slave (
      input  in_valid, in_data, in_ctrl, flush, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, count
   );

   modport master (
      output in_valid, in_data, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, count
   );

endinterface

// File: rtl/pipe_entry.sv
// One pipeline entry: valid flag plus control and data payload, with load,
// clear_valid (payload kept) and synchronous reset.
module pipe_entry #(
   parameter int DATA_W = pipe_pkg::DEF_DATA_W,
   parameter int CTRL_W = pipe_pkg::DEF_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear_valid,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   // NOTE: payload is reset too, giving a defined zero on out_data after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (clear_valid) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= d_data;
         ctrl  <= d_ctrl;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with optional two-entry skid buffer
// (registered in_ready), flush-to-bubble and bubble masking of control.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter bit SKID   = 1'b1
) (
   input logic clk,
   input logic rst,
   pipe_stage_reg_if.slave bus
);

   pipe_state_t       st;
   logic              in_ready;
   logic              in_fire;
   logic              out_fire;
   logic              head_load;
   logic              head_clr;
   logic [DATA_W-1:0] head_d_data;
   logic [CTRL_W-1:0] head_d_ctrl;
   logic              head_valid;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] head_ctrl;

   assign in_fire  = bus.in_valid & in_ready;
   assign out_fire = head_valid & bus.out_ready;

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
      .clk         (clk),
      .rst         (rst),
      .load        (head_load),
      .clear_valid (head_clr),
      .d_data      (head_d_data),
      .d_ctrl      (head_d_ctrl),
      .valid       (head_valid),
      .data        (head_data),
      .ctrl        (head_ctrl)
   );

   if (SKID) begin : gen_skid
      pipe_state_t       st_nxt;
      logic              in_ready_r;
      logic              skid_load;
      logic              skid_clr;
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
         .clk         (clk),
         .rst         (rst),
         .load        (skid_load),
         .clear_valid (skid_clr),
         .d_data      (bus.in_data),
         .d_ctrl      (bus.in_ctrl),
         .valid       (skid_valid),
         .data        (skid_data),
         .ctrl        (skid_ctrl)
      );

      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      always_comb begin
         st_nxt      = st;
         head_load   = 1'b0;
         head_clr    = 1'b0;
         skid_load   = 1'b0;
         skid_clr    = 1'b0;
         head_d_data = bus.in_data;
         head_d_ctrl = bus.in_ctrl;
         if (bus.flush) begin
            st_nxt   = ST_EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
         end else begin
            unique case (st)
               ST_EMPTY: if (in_fire) begin
                  st_nxt    = ST_ONE;
                  head_load = 1'b1;
               end
               ST_ONE: begin
                  if (in_fire && !out_fire) begin
                     st_nxt    = ST_FULL;
                     skid_load = 1'b1;
                  end else if (in_fire) begin
                     head_load = 1'b1;
                  end else if (out_fire) begin
                     st_nxt   = ST_EMPTY;
                     head_clr = 1'b1;
                  end
               end
               ST_FULL: if (out_fire && skid_valid) begin
                  st_nxt      = ST_ONE;
                  head_load   = 1'b1;
                  head_d_data = skid_data;
                  head_d_ctrl = skid_ctrl;
                  skid_clr    = 1'b1;
               end
               default: st_nxt = ST_EMPTY;
            endcase
         end
      end

      // Ready is a flop so upstream never sees a path from out_ready.
      always_ff @(posedge clk) begin
         if (rst) begin
            st         <= ST_EMPTY;
            in_ready_r <= 1'b1;
         end else begin
            st         <= st_nxt;
            in_ready_r <= (st_nxt != ST_FULL);
         end
      end

      assign in_ready = in_ready_r;
   end else begin : gen_single
      assign in_ready = !head_valid | bus.out_ready;

      always_comb begin
         head_d_data = bus.in_data;
         head_d_ctrl = bus.in_ctrl;
         head_load   = in_fire & !bus.flush;
         head_clr    = bus.flush | (out_fire & !in_fire);
      end

      always_ff @(posedge clk) begin
         if (rst)            st <= ST_EMPTY;
         else if (head_load) st <= ST_ONE;
         else if (head_clr)  st <= ST_EMPTY;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = head_valid;
   assign bus.out_data  = head_data;
   assign bus.out_ctrl  = head_valid ? head_ctrl : '0;
   assign bus.count     = st;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: directed vectors on a skid and a non-skid stage, with a
// per-instance scoreboard monitor checking ordering and payload on every out_fire.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(12)) b ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(12)) c ();

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(12), .SKID(1'b1)) u_dut_skid (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(12), .SKID(1'b0)) u_dut_single (
      .clk (clk),
      .rst (rst),
      .bus (c.slave)
   );

   logic [43:0] q_skid[$];
   logic [43:0] q_single[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboards: out_fire pops and compares before the cycle's in_fire pushes.
   always @(negedge clk) begin
      logic [43:0] e;
      if (!rst) begin
         if (b.out_valid && b.out_ready) begin
            if (q_skid.size() == 0) begin
               checks++; errors++;
               $display("FAIL skid_unexpected_beat: got %0h expected none", b.out_data);
            end else begin
               e = q_skid.pop_front();
               check("skid_sb_data", b.out_data, e[31:0]);
               check("skid_sb_ctrl", {20'd0, b.out_ctrl}, {20'd0, e[43:32]});
            end
         end
         if (b.flush) q_skid.delete();
         else if (b.in_valid && b.in_ready) q_skid.push_back({b.in_ctrl, b.in_data});
      end
   end

   always @(negedge clk) begin
      logic [43:0] e;
      if (!rst) begin
         if (c.out_valid && c.out_ready) begin
            if (q_single.size() == 0) begin
               checks++; errors++;
               $display("FAIL single_unexpected_beat: got %0h expected none", c.out_data);
            end else begin
               e = q_single.pop_front();
               check("single_sb_data", c.out_data, e[31:0]);
               check("single_sb_ctrl", {20'd0, c.out_ctrl}, {20'd0, e[43:32]});
            end
         end
         if (c.flush) q_single.delete();
         else if (c.in_valid && c.in_ready) q_single.push_back({c.in_ctrl, c.in_data});
      end
   end

   initial begin
      b.in_valid = 1'b1; b.in_data = 32'hDEAD; b.in_ctrl = 12'hFFF;
      b.flush = 1'b0; b.out_ready = 1'b1;
      c.in_valid = 1'b0; c.in_data = '0; c.in_ctrl = '0;
      c.flush = 1'b0; c.out_ready = 1'b1;

      // Reset with a valid beat offered
      tick(); tick();
      check("rst_out_valid", {31'd0, b.out_valid}, 32'd0);
      check("rst_out_ctrl", {20'd0, b.out_ctrl}, 32'd0);
      check("rst_count", {30'd0, b.count}, 32'd0);
      rst = 1'b0; b.in_valid = 1'b0;
      tick();
      check("rst_in_ready", {31'd0, b.in_ready}, 32'd1);
      check("rst_no_beat", {31'd0, b.out_valid}, 32'd0);

      // Streaming, one beat per cycle
      for (int i = 0; i < 8; i++) begin
         b.in_valid = 1'b1; b.in_data = 32'h11 + i; b.in_ctrl = 12'h100 + 12'(i);
         tick();
         check("stream_valid", {31'd0, b.out_valid}, 32'd1);
         check("stream_data", b.out_data, 32'h11 + i);
         check("stream_count", {30'd0, b.count}, 32'd1);
      end
      b.in_valid = 1'b0;
      tick();
      check("stream_drain_valid", {31'd0, b.out_valid}, 32'd0);
      check("stream_drain_count", {30'd0, b.count}, 32'd0);

      // Stall fills the skid entry; third beat waits upstream
      b.out_ready = 1'b0;
      b.in_valid = 1'b1; b.in_data = 32'hA1; b.in_ctrl = 12'h0A1;
      tick();
      check("skid_a1_count", {30'd0, b.count}, 32'd1);
      check("skid_a1_ready", {31'd0, b.in_ready}, 32'd1);
      b.in_data = 32'hA2; b.in_ctrl = 12'h0A2;
      tick();
      check("skid_a2_count", {30'd0, b.count}, 32'd2);
      check("skid_a2_ready", {31'd0, b.in_ready}, 32'd0);
      b.in_data = 32'hA3; b.in_ctrl = 12'h0A3;
      tick(); tick();
      check("skid_hold_count", {30'd0, b.count}, 32'd2);
      check("skid_hold_ready", {31'd0, b.in_ready}, 32'd0);
      check("skid_hold_data", b.out_data, 32'hA1);
      check("skid_hold_ctrl", {20'd0, b.out_ctrl}, 32'h0A1);
      b.out_ready = 1'b1;
      tick();
      check("skid_rel_data", b.out_data, 32'hA2);
      check("skid_rel_count", {30'd0, b.count}, 32'd1);
      check("skid_rel_ready", {31'd0, b.in_ready}, 32'd1);
      tick();
      check("skid_a3_data", b.out_data, 32'hA3);
      b.in_valid = 1'b0;
      tick();
      check("skid_empty_count", {30'd0, b.count}, 32'd0);

      // Flush while FULL with a beat offered
      b.out_ready = 1'b0;
      b.in_valid = 1'b1; b.in_data = 32'hB1; b.in_ctrl = 12'h0B1;
      tick();
      b.in_data = 32'hB2; b.in_ctrl = 12'h0B2;
      tick();
      b.in_data = 32'hB3; b.in_ctrl = 12'h0B3; b.flush = 1'b1;
      tick();
      b.flush = 1'b0; b.in_valid = 1'b0;
      check("flush_full_valid", {31'd0, b.out_valid}, 32'd0);
      check("flush_full_ctrl", {20'd0, b.out_ctrl}, 32'd0);
      check("flush_full_count", {30'd0, b.count}, 32'd0);
      check("flush_full_ready", {31'd0, b.in_ready}, 32'd1);
      b.out_ready = 1'b1;
      tick();
      check("flush_full_no_b3", {31'd0, b.out_valid}, 32'd0);

      // Flush in ONE with in_fire = 1, then with out_fire completing
      b.out_ready = 1'b0;
      b.in_valid = 1'b1; b.in_data = 32'hC1; b.in_ctrl = 12'h0C1;
      tick();
      b.in_data = 32'hC2; b.flush = 1'b1;
      tick();
      b.flush = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
      check("flush_one_valid", {31'd0, b.out_valid}, 32'd0);
      check("flush_one_count", {30'd0, b.count}, 32'd0);
      b.in_valid = 1'b1; b.in_data = 32'hD1; b.in_ctrl = 12'h0D1;
      tick();
      b.in_data = 32'hD2; b.flush = 1'b1;
      tick();
      b.flush = 1'b0; b.in_valid = 1'b0;
      check("flush_fire_valid", {31'd0, b.out_valid}, 32'd0);
      check("flush_fire_count", {30'd0, b.count}, 32'd0);

      // Bubble mask: control never leaks from an empty stage
      b.in_valid = 1'b0; b.in_ctrl = 12'hFFF; b.in_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         b.out_ready = i[0];
         tick();
         check("bubble_ctrl", {20'd0, b.out_ctrl}, 32'd0);
         check("bubble_valid", {31'd0, b.out_valid}, 32'd0);
      end

      // Single-entry stage: ready follows out_ready once occupied
      c.in_valid = 1'b1; c.in_data = 32'hD01; c.in_ctrl = 12'h3C1; c.out_ready = 1'b1;
      #1 check("single_empty_ready", {31'd0, c.in_ready}, 32'd1);
      tick();
      check("single_d1_data", c.out_data, 32'hD01);
      check("single_d1_count", {30'd0, c.count}, 32'd1);
      c.in_data = 32'hD02; c.in_ctrl = 12'h3C2; c.out_ready = 1'b0;
      #1 check("single_stall_ready", {31'd0, c.in_ready}, 32'd0);
      tick();
      check("single_stall_data", c.out_data, 32'hD01);
      check("single_stall_count", {30'd0, c.count}, 32'd1);
      c.out_ready = 1'b1;
      #1 check("single_go_ready", {31'd0, c.in_ready}, 32'd1);
      tick();
      check("single_d2_data", c.out_data, 32'hD02);
      c.in_data = 32'hD03; c.in_ctrl = 12'h3C3;
      tick();
      check("single_d3_data", c.out_data, 32'hD03);
      check("single_d3_ctrl", {20'd0, c.out_ctrl}, 32'h3C3);
      c.in_valid = 1'b0;
      tick();
      check("single_drain_valid", {31'd0, c.out_valid}, 32'd0);
      check("single_drain_count", {30'd0, c.count}, 32'd0);

      tick(); tick();
      check("skid_sb_left", q_skid.size(), 32'd0);
      check("single_sb_left", q_single.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
